// File: rtl/basic_math_pkg.sv
// Shared fixed-point math types for the ray pipeline: Q format default,
// 3-vector type, int limits, divider FSM states and a 33-bit magnitude helper.
package basic_math_pkg;

    localparam int Q_BITS_DEF = 10;

    typedef int vec3_t [2:0];

    localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } div_state_t;

    // 33 bits so that -2^31 has a representable magnitude
    function automatic logic [32:0] abs33(input logic [31:0] v);
        logic [32:0] r;
        if (v[31]) begin
            r = 33'd0 - {1'b1, v};
        end else begin
            r = {1'b0, v};
        end
        return r;
    endfunction

endpackage

// File: rtl/vec_div_seq_udiv_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module udiv_step
    import basic_math_pkg::*;
(
    input  logic [32:0] rem_i,
    input  logic [32:0] div_i,
    input  logic        bit_i,
    output logic [32:0] rem_o,
    output logic        q_o
);

    logic [33:0] shifted_s;

    assign shifted_s = {rem_i, bit_i};

    // Remainder stays below the divisor, so the 33-bit result never overflows
    always_comb begin
        rem_o = shifted_s[32:0];
        q_o   = 1'b0;
        if (shifted_s >= {1'b0, div_i}) begin
            rem_o = shifted_s[32:0] - div_i;
            q_o   = 1'b1;
        end else begin
            rem_o = shifted_s[32:0];
            q_o   = 1'b0;
        end
    end

endmodule

// File: rtl/vec_div_seq.sv
// Serial fixed-point vector divide: out[i] = (x[i] << Q_BITS) / d, components
// 0..2 through one shared restoring divider, valid/ready on both sides.
module vec_div_seq
    import basic_math_pkg::*;
#(
    parameter int Q_BITS = Q_BITS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  vec3_t       x,
    input  logic [31:0] d,
    output logic        out_valid,
    input  logic        out_ready,
    output vec3_t       out,
    output logic        dbz,
    output logic [2:0]  sat
);

    localparam int DW = 32 + Q_BITS;
    localparam int CW = $clog2(DW);
    localparam logic [DW-1:0] POS_LIMIT = DW'(INT_MAX);
    localparam logic [DW-1:0] NEG_LIMIT = DW'(INT_MIN);

    div_state_t      state_q;
    logic [1:0]      comp_q;
    vec3_t           x_q;
    logic            d_neg_q;
    logic [32:0]     dabs_q;
    logic [32:0]     rem_q;
    logic [DW-1:0]   dq_q;
    logic [CW-1:0]   cnt_q;
    logic            neg_q;
    vec3_t           out_q;
    logic            out_valid_q;
    logic            dbz_q;
    logic [2:0]      sat_q;

    logic [32:0]     xabs_d;
    logic [DW-1:0]   dividend_d;
    logic [32:0]     rem_d;
    logic            qbit_d;
    logic [31:0]     res_d;
    logic            sat_bit_d;

    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign dbz       = dbz_q;
    assign sat       = sat_q;

    assign xabs_d     = abs33(x_q[comp_q]);
    assign dividend_d = DW'(xabs_d) << Q_BITS;

    // dq_q holds the dividend in its upper bits and collects quotient bits at the bottom
    udiv_step u_step (
        .rem_i (rem_q),
        .div_i (dabs_q),
        .bit_i (dq_q[DW-1]),
        .rem_o (rem_d),
        .q_o   (qbit_d)
    );

    // Sign, divide-by-zero and saturation handling for the finished component
    always_comb begin
        res_d     = 32'h0000_0000;
        sat_bit_d = 1'b0;
        if (dabs_q == 33'd0) begin
            if (x_q[comp_q] == 32'sd0) begin
                res_d     = 32'h0000_0000;
                sat_bit_d = 1'b0;
            end else if (x_q[comp_q] < 32'sd0) begin
                res_d     = INT_MIN;
                sat_bit_d = 1'b1;
            end else begin
                res_d     = INT_MAX;
                sat_bit_d = 1'b1;
            end
        end else if (neg_q) begin
            if (dq_q > NEG_LIMIT) begin
                res_d     = INT_MIN;
                sat_bit_d = 1'b1;
            end else begin
                res_d     = 32'h0000_0000 - dq_q[31:0];
                sat_bit_d = 1'b0;
            end
        end else begin
            if (dq_q > POS_LIMIT) begin
                res_d     = INT_MAX;
                sat_bit_d = 1'b1;
            end else begin
                res_d     = dq_q[31:0];
                sat_bit_d = 1'b0;
            end
        end
    end

    // Control FSM with registered result, flags and handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            comp_q      <= 2'd0;
            x_q         <= '{default: 32'sd0};
            d_neg_q     <= 1'b0;
            dabs_q      <= 33'd0;
            rem_q       <= 33'd0;
            dq_q        <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            out_q       <= '{default: 32'sd0};
            out_valid_q <= 1'b0;
            dbz_q       <= 1'b0;
            sat_q       <= 3'b000;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        x_q     <= x;
                        d_neg_q <= d[31];
                        dabs_q  <= abs33(d);
                        comp_q  <= 2'd0;
                        out_q   <= '{default: 32'sd0};
                        dbz_q   <= 1'b0;
                        sat_q   <= 3'b000;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    rem_q   <= 33'd0;
                    dq_q    <= dividend_d;
                    cnt_q   <= CW'(DW - 1);
                    neg_q   <= x_q[comp_q][31] ^ d_neg_q;
                    state_q <= S_DIV;
                end
                S_DIV: begin
                    rem_q <= rem_d;
                    dq_q  <= {dq_q[DW-2:0], qbit_d};
                    if (cnt_q == '0) begin
                        state_q <= S_FIX;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_FIX: begin
                    out_q[comp_q] <= res_d;
                    sat_q[comp_q] <= sat_bit_d;
                    if (dabs_q == 33'd0) begin
                        dbz_q <= 1'b1;
                    end
                    if (comp_q == 2'd2) begin
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        comp_q  <= comp_q + 2'd1;
                        state_q <= S_LOAD;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vec_div_seq.sv
// Randomized self-checking bench for vec_div_seq against a plain-arithmetic
// reference of the fixed-point divide.
module tb_vec_div_seq;
    import basic_math_pkg::*;

    localparam int Q   = 10;
    localparam int LAT = 3 * (32 + Q + 2);

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    vec3_t       x;
    logic [31:0] d;
    logic        out_valid;
    logic        out_ready;
    vec3_t       out;
    logic        dbz;
    logic [2:0]  sat;

    int checks = 0;
    int errors = 0;
    int exp_out [3];
    bit exp_sat [3];
    bit exp_dbz;

    always #5 clk = ~clk;

    vec_div_seq #(.Q_BITS(Q)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .d         (d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .dbz       (dbz),
        .sat       (sat)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: exact integer quotient truncated toward zero, then clamped to int
    function automatic int model(input int xv, input int dv, output bit s);
        longint num;
        longint q;
        s = 1'b0;
        if (dv == 0) begin
            if (xv == 0) return 0;
            s = 1'b1;
            return (xv > 0) ? 32'sh7FFF_FFFF : 32'sh8000_0000;
        end
        num = longint'(xv) * (longint'(1) <<< Q);
        q   = num / longint'(dv);
        if (q > 64'sd2147483647) begin
            s = 1'b1;
            return 32'sh7FFF_FFFF;
        end
        if (q < -64'sd2147483648) begin
            s = 1'b1;
            return 32'sh8000_0000;
        end
        return int'(q);
    endfunction

    task automatic pin(input int xv, input int dv, input int e, input bit es);
        bit s;
        int r;
        r = model(xv, dv, s);
        chk("model_pin", r, e);
        chk("model_pin_sat", s, es);
    endtask

    function automatic int rnd_val();
        case ($urandom_range(0, 3))
            0:       return int'($urandom);
            1:       return int'($urandom_range(0, 4096)) * ($urandom_range(0, 1) ? 1 : -1);
            2:       return int'($urandom_range(0, 1 << 22)) * ($urandom_range(0, 1) ? 1 : -1);
            default: return 0;
        endcase
    endfunction

    // Whenever a result is presented it must match the reference and stay put
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            for (int i = 0; i < 3; i++) chk("out", out[i], exp_out[i]);
            chk("dbz", dbz, exp_dbz);
            chk("sat", sat, {exp_sat[2], exp_sat[1], exp_sat[0]});
            chk("in_ready_done", in_ready, 0);
        end
    end

    task automatic accept(input int a0, input int a1, input int a2, input int dv);
        int w;
        int av [3];
        bit s;
        av = '{a0, a1, a2};
        w = 0;
        while (!in_ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        chk("ready_wait", in_ready, 1);
        for (int i = 0; i < 3; i++) begin
            exp_out[i] = model(av[i], dv, s);
            exp_sat[i] = s;
        end
        exp_dbz = (dv == 0);
        for (int i = 0; i < 3; i++) x[i] = av[i];
        d        = dv;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("clr_out", out[0] | out[1] | out[2], 0);
        chk("clr_flags", {dbz, sat}, 0);
        chk("busy_ready", in_ready, 0);
    endtask

    task automatic run_op(input int a0, input int a1, input int a2, input int dv, input int hold);
        int lat;
        accept(a0, a1, a2, dv);
        lat = 0;
        while (!out_valid && lat < LAT + 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (lat == 60) begin
                in_valid = 1'b1;
                x[0] = int'($urandom);
                x[1] = int'($urandom);
                d    = $urandom;
            end else begin
                in_valid = 1'b0;
            end
        end
        chk("latency", lat, LAT);
        for (int h = 0; h < hold; h++) begin
            in_valid = ($urandom_range(0, 1) == 1);
            x[0] = int'($urandom);
            d    = $urandom;
            @(posedge clk);
            @(negedge clk);
        end
        out_ready = 1'b1;
        in_valid  = ($urandom_range(0, 1) == 1);
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("out_valid_drop", out_valid, 0);
        chk("idle_ready", in_ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "bench timeout");
    end

    initial begin
        int a0, a1, a2, dv, quiet;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x         = '{default: 0};
        d         = 32'h0;

        pin(2048, 2048, 1024, 1'b0);
        pin(-3072, 2048, -1536, 1'b0);
        pin(-1024, 3072, -341, 1'b0);
        pin(1, 3072, 0, 1'b0);
        pin(5, 0, 32'sh7FFF_FFFF, 1'b1);
        pin(-5, 0, 32'sh8000_0000, 1'b1);
        pin(0, 0, 0, 1'b0);
        pin(32'sh4000_0000, 1, 32'sh7FFF_FFFF, 1'b1);
        pin(32'sh8000_0000, 1, 32'sh8000_0000, 1'b1);
        pin(1024, 1, 1048576, 1'b0);
        pin(-2097152, 1, 32'sh8000_0000, 1'b0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out", out[0] | out[1] | out[2], 0);
        chk("rst_flags", {dbz, sat}, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", in_ready, 1);

        run_op(2048, -3072, 1024, 2048, 0);
        run_op(-1024, 1, 0, 3072, 1);
        run_op(5, -5, 0, 0, 10);
        run_op(32'sh4000_0000, 32'sh8000_0000, 1024, 1, 2);
        run_op(-2097152, 32'sh8000_0000, -7, 32'sh8000_0000, 0);
        run_op(7, -7, 32'sh7FFF_FFFF, -1, 0);

        // Abort mid-operation, after component 0 has already been written
        accept(3000, -7000, 12345, 2048);
        repeat (49) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_ready_in_rst", in_ready, 0);
        rst = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_out", out[0] | out[1] | out[2], 0);
        chk("abort_flags", {dbz, sat}, 0);
        chk("abort_ready", in_ready, 1);
        quiet = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (out_valid) quiet++;
        end
        chk("abort_no_result", quiet, 0);
        run_op(-9000, 4500, 1, -3, 3);

        for (int k = 0; k < 16; k++) begin
            a0 = rnd_val();
            a1 = rnd_val();
            a2 = rnd_val();
            if ($urandom_range(0, 5) == 0) begin
                dv = 0;
            end else begin
                dv = rnd_val();
                if (dv == 0) dv = 1;
            end
            run_op(a0, a1, a2, dv, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
